// File: rtl/norm_pkg.sv
// Shared types and helpers for the leading-one normalization controller.
package norm_pkg;

  // Operand width shared with the downstream one-hot left shifter.
  localparam int unsigned DEF_WIDTH = 8;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit index -> one-hot shift control word.
  function automatic logic [DEF_WIDTH-1:0] onehot(input int unsigned idx);
    logic [DEF_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < DEF_WIDTH; i++) begin
      if (i == idx) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/norm_shift_ctrl.sv
// Sequential MSB-first leading-one scanner driving a one-hot left shifter.
module norm_shift_ctrl
  import norm_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] D_in,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] N,
  output logic [CW-1:0]    lzc,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);
  localparam logic [CW-1:0] LZC_TOP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LZC_ALL = CW'(WIDTH);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [CW-1:0]    lzc_q, lzc_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath update; results hold until the next accepted start.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    d_d     = d_q;
    n_d     = n_q;
    lzc_d   = lzc_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          d_d     = D_in;
          idx_d   = IDX_TOP;
          n_d     = '0;
          zero_d  = 1'b0;
          lzc_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end

      SCAN: begin
        // Requests arriving mid-scan are dropped, not queued.
        if (d_q[idx_q]) begin
          n_d     = WIDTH'(onehot(int'(idx_q)));
          lzc_d   = LZC_TOP - CW'(idx_q);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          n_d     = '0;
          zero_d  = 1'b1;
          lzc_d   = LZC_ALL;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      DONE: begin
        // Back-to-back start is accepted in the result cycle.
        if (start) begin
          d_d     = D_in;
          idx_d   = IDX_TOP;
          n_d     = '0;
          zero_d  = 1'b0;
          lzc_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      d_q     <= '0;
      n_q     <= '0;
      lzc_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      n_q     <= n_d;
      lzc_q   <= lzc_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign D    = d_q;
  assign N    = n_q;
  assign lzc  = lzc_q;
  assign zero = zero_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
